// File: rtl/crossy_pkg.sv
// Shared types and default constants for the game-outcome sequencer.
package crossy_pkg;

  typedef enum logic [2:0] {
    READY = 3'd0,
    PLAY  = 3'd1,
    CRASH = 3'd2,
    WIN   = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam int HOLD_TICKS_DEF = 3;
  localparam int LIVES_DEF      = 3;
  localparam int SCORE_W_DEF    = 4;

  // Width needed to hold a lives count from 0 up to n inclusive.
  function automatic int lives_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/outcome_controller_if.sv
// Playfield/display-facing signal bundle of the outcome sequencer.
interface outcome_controller_if
  import crossy_pkg::*;
#(
  parameter int LIVES   = LIVES_DEF,
  parameter int SCORE_W = SCORE_W_DEF
);
  localparam int LW = lives_width(LIVES);

  logic               tick_en;
  logic               collision;
  logic               at_goal;
  logic               start;
  logic               crash_check;
  logic               victory;
  logic               msg_done;
  logic               respawn;
  logic               freeze;
  logic               game_over;
  logic [LW-1:0]      lives_left;
  logic [SCORE_W-1:0] score;

  modport master (
    output tick_en, collision, at_goal, start,
    input  crash_check, victory, msg_done, respawn, freeze, game_over, lives_left, score
  );

  modport slave (
    input  tick_en, collision, at_goal, start,
    output crash_check, victory, msg_done, respawn, freeze, game_over, lives_left, score
  );
endinterface

// File: rtl/outcome_controller_hold_timer.sv
// Tick counter for outcome hold periods; done strobes on the N-th counted tick.
module hold_timer #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick_en,
  output logic done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] count_q, count_d;

  // clr dominates so a tick arriving while held clear is never counted.
  assign done = tick_en && !clr && (count_q == CW'(N - 1));

  always_comb begin
    count_d = count_q;
    if (clr || done) begin
      count_d = '0;
    end else if (tick_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/outcome_controller.sv
// Game-outcome sequencer: latches CRASH/WIN, holds for a number of ticks,
// then pulses msg_done/respawn; also owns the lives and score counters.
module outcome_controller
  import crossy_pkg::*;
#(
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int LIVES      = LIVES_DEF,
  parameter int SCORE_W    = SCORE_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  outcome_controller_if.slave  bus
);
  localparam int LW = lives_width(LIVES);

  game_state_t        state_q, state_d;
  logic [LW-1:0]      lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               in_hold;
  logic               hold_done;
  logic               msg_done_d;
  logic               respawn_d;

  assign in_hold = (state_q == CRASH) || (state_q == WIN);

  // Timer sits cleared outside the hold states, so a tick in the entry cycle is ignored.
  hold_timer #(
    .N (HOLD_TICKS)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_hold),
    .tick_en (bus.tick_en),
    .done    (hold_done)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    msg_done_d = 1'b0;
    respawn_d  = 1'b0;
    case (state_q)
      READY: begin
        if (bus.start) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
        end
      end
      PLAY: begin
        if (bus.collision) begin
          state_d = CRASH;
          if (lives_q != '0) lives_d = lives_q - 1'b1;
        end else if (bus.at_goal) begin
          state_d = WIN;
          if (score_q != '1) score_d = score_q + 1'b1;
        end
      end
      CRASH: begin
        if (hold_done) begin
          msg_done_d = 1'b1;
          respawn_d  = 1'b1;
          state_d    = (lives_q == '0) ? OVER : PLAY;
        end
      end
      WIN: begin
        if (hold_done) begin
          msg_done_d = 1'b1;
          respawn_d  = 1'b1;
          state_d    = PLAY;
        end
      end
      OVER: begin
        if (bus.start) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
          lives_d   = LW'(LIVES);
          score_d   = '0;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= READY;
      lives_q <= LW'(LIVES);
      score_q <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
    end
  end

  assign bus.crash_check = (state_q == CRASH);
  assign bus.victory     = (state_q == WIN);
  assign bus.freeze      = (state_q != PLAY);
  assign bus.game_over   = (state_q == OVER);
  assign bus.msg_done    = msg_done_d;
  assign bus.respawn     = respawn_d;
  assign bus.lives_left  = lives_q;
  assign bus.score       = score_q;
endmodule
